// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: upstream FIFO read port plus downstream valid/ready stream and status.
interface fifo_rd_stream_if #(parameter int FIFO_WIDTH = 16);
   logic                  enable, flush, fifo_empty, fifo_underflow, fifo_rd_en;
   logic                  m_ready, m_valid, underflow_err;
   logic [FIFO_WIDTH-1:0] fifo_data_out, m_data;
   logic [15:0]           rd_count;
   modport master (
      output enable, flush, fifo_empty, fifo_underflow, fifo_data_out, m_ready,
      input  fifo_rd_en, m_valid, m_data, rd_count, underflow_err
   );
   modport slave (
      input  enable, flush, fifo_empty, fifo_underflow, fifo_data_out, m_ready,
      output fifo_rd_en, m_valid, m_data, rd_count, underflow_err
   );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pulls words from an upstream FIFO into a 2-entry skid buffer and
// presents them in order on a valid/ready stream, with flush and sticky underflow.
module fifo_rd_stream #(parameter int FIFO_WIDTH = 16) (
   input  logic            clk,
   input  logic            rst_n,
   fifo_rd_stream_if.slave bus
);
   typedef enum logic {RUN, FLUSH} state_t;
   state_t                state, state_nxt;
   logic [FIFO_WIDTH-1:0] mem [2];
   logic                  head, tail, pend, cap, xfer;
   logic [1:0]            occ;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   always_comb
      state_nxt = (state == RUN) ? (bus.flush ? FLUSH : RUN)
                                 : ((!bus.flush && !pend) ? RUN : FLUSH);
   // A transfer this cycle frees a slot, so the read gate credits it to sustain one word per cycle.
   always_comb begin
      bus.m_valid    = (occ != 2'd0) && (state == RUN);
      bus.m_data     = mem[head];
      xfer           = bus.m_valid && bus.m_ready;
      cap            = pend && (state == RUN);
      bus.fifo_rd_en = bus.enable && !bus.flush && !bus.fifo_empty && (state == RUN) && rst_n
                       && ((3'(occ) + 3'(pend) - 3'(xfer)) < 3'd2);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         occ               <= 2'd0;
         pend              <= 1'b0;
         head              <= 1'b0;
         tail              <= 1'b0;
         mem[0]            <= '0;
         mem[1]            <= '0;
         bus.rd_count      <= 16'd0;
         bus.underflow_err <= 1'b0;
      end else begin
         pend <= bus.fifo_rd_en;
         if (bus.fifo_underflow) bus.underflow_err <= 1'b1;
         if (xfer) bus.rd_count <= bus.rd_count + 16'd1;
         if (state == FLUSH || bus.flush) begin
            occ  <= 2'd0;
            head <= 1'b0;
            tail <= 1'b0;
         end else begin
            if (cap) begin
               mem[tail] <= bus.fifo_data_out;
               tail      <= ~tail;
            end
            if (xfer) head <= ~head;
            occ <= occ + 2'(cap) - 2'(xfer);
         end
      end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed checks of fifo_rd_stream against a simple upstream FIFO model.
module tb_fifo_rd_stream;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] src [256];
   logic [7:0]  rd_ptr = 8'd0;
   logic [7:0]  wr_ptr = 8'd0;
   logic        inf = 1'b0;
   int unsigned xfers = 0;
   int unsigned x0;
   int          errs = 0, checks = 0, n, m, guard;
   fifo_rd_stream_if #(.FIFO_WIDTH(16)) bus ();
   fifo_rd_stream #(.FIFO_WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   assign bus.fifo_empty = !inf && (rd_ptr == wr_ptr);
   // Upstream FIFO: read data appears the cycle after an accepted read.
   always @(posedge clk) begin
      if (bus.fifo_rd_en) begin
         bus.fifo_data_out <= inf ? {8'h00, rd_ptr} : src[rd_ptr];
         rd_ptr            <= rd_ptr + 8'd1;
      end
      if (bus.m_valid && bus.m_ready) xfers <= xfers + 1;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic load(input logic [15:0] w);
      src[wr_ptr] = w;
      wr_ptr      = wr_ptr + 8'd1;
   endtask
   task automatic wait_mv(input string tag);
      int k = 0;
      while (!bus.m_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!bus.m_valid) chk(tag, bus.m_valid, 1);
   endtask
   initial begin
      rst_n = 1'b0;
      bus.enable = 1'b0;
      bus.flush = 1'b0;
      bus.fifo_underflow = 1'b0;
      bus.m_ready = 1'b0;
      #12;
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_rd_en", bus.fifo_rd_en, 0);
      chk("rst_count", bus.rd_count, 0);
      chk("rst_uflow", bus.underflow_err, 0);
      chk("rst_m_data", bus.m_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      load(16'h000A); load(16'h000B); load(16'h000C);
      bus.m_ready = 1'b1;
      bus.enable  = 1'b1;
      #1 chk("lat_rd_en", bus.fifo_rd_en, 1);
      @(negedge clk) chk("lat_edge1", bus.m_valid, 0);
      @(negedge clk) chk("word_a", {bus.m_valid, bus.m_data}, {1'b1, 16'h000A});
      @(negedge clk) chk("word_b", {bus.m_valid, bus.m_data}, {1'b1, 16'h000B});
      @(negedge clk) chk("word_c", {bus.m_valid, bus.m_data}, {1'b1, 16'h000C});
      @(negedge clk);
      chk("drained", bus.m_valid, 0);
      chk("count3", bus.rd_count, 3);
      bus.m_ready = 1'b0;
      load(16'h0101); load(16'h0102); load(16'h0103); load(16'h0104);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         #1 if (bus.fifo_rd_en) n++;
         @(negedge clk);
      end
      chk("stall_reads", n, 2);
      chk("stall_hold", {bus.m_valid, bus.m_data}, {1'b1, 16'h0101});
      bus.m_ready = 1'b1;
      #1 chk("stall_w0", {bus.m_valid, bus.m_data}, {1'b1, 16'h0101});
      @(negedge clk) chk("stall_w1", {bus.m_valid, bus.m_data}, {1'b1, 16'h0102});
      @(negedge clk) chk("stall_w2", {bus.m_valid, bus.m_data}, {1'b1, 16'h0103});
      @(negedge clk) chk("stall_w3", {bus.m_valid, bus.m_data}, {1'b1, 16'h0104});
      @(negedge clk) chk("count7", bus.rd_count, 7);
      n = 0;
      m = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.fifo_rd_en) n++;
         if (bus.m_valid) m++;
      end
      chk("empty_reads", n, 0);
      chk("empty_valid", m, 0);
      bus.fifo_underflow = 1'b1;
      @(negedge clk);
      bus.fifo_underflow = 1'b0;
      chk("uflow_set", bus.underflow_err, 1);
      repeat (5) @(negedge clk);
      chk("uflow_sticky", bus.underflow_err, 1);
      bus.m_ready = 1'b0;
      load(16'h0201); load(16'h0202); load(16'h0203); load(16'h0204);
      repeat (2) @(negedge clk);
      chk("pre_flush", {bus.m_valid, bus.m_data}, {1'b1, 16'h0201});
      bus.flush = 1'b1;
      #1 chk("flush_rd_en", bus.fifo_rd_en, 0);
      @(negedge clk);
      chk("flush_valid", bus.m_valid, 0);
      chk("flush_count", bus.rd_count, 7);
      bus.flush   = 1'b0;
      bus.m_ready = 1'b1;
      wait_mv("flush_resume");
      chk("after_flush0", bus.m_data, 16'h0203);
      @(negedge clk) chk("after_flush1", {bus.m_valid, bus.m_data}, {1'b1, 16'h0204});
      @(negedge clk) chk("count9", bus.rd_count, 9);
      bus.m_ready = 1'b0;
      load(16'h0301); load(16'h0302); load(16'h0303); load(16'h0304);
      repeat (3) @(negedge clk);
      chk("full_valid", {bus.m_valid, bus.m_data}, {1'b1, 16'h0301});
      #2 rst_n = 1'b0;
      #1;
      chk("async_m_valid", bus.m_valid, 0);
      chk("async_count", bus.rd_count, 0);
      chk("async_rd_en", bus.fifo_rd_en, 0);
      chk("async_m_data", bus.m_data, 0);
      chk("async_uflow", bus.underflow_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.m_ready = 1'b1;
      #1 chk("fresh_rd_en", bus.fifo_rd_en, 1);
      wait_mv("post_rst");
      chk("post_rst_w0", bus.m_data, 16'h0303);
      @(negedge clk) chk("post_rst_w1", {bus.m_valid, bus.m_data}, {1'b1, 16'h0304});
      @(negedge clk) chk("post_rst_count", bus.rd_count, 2);
      bus.enable = 1'b0;
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      x0 = xfers;
      inf = 1'b1;
      bus.enable = 1'b1;
      guard = 0;
      while (xfers - x0 < 32'd65536 && guard < 70000) begin
         @(negedge clk);
         guard++;
      end
      chk("wrap_reached", xfers - x0, 65536);
      chk("wrap_zero", bus.rd_count, 0);
      @(negedge clk);
      chk("wrap_one", bus.rd_count, 1);
      bus.enable = 1'b0;
      inf = 1'b0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
